// File: rtl/artemis_mcb_port_master_pkg.sv
// Shared definitions for the Artemis MCB port master.
//   - MCB command encodings (plain and auto-precharge variants, refresh)
//   - FSM state enum
//   - MCB data/address/burst width constants
package artemis_mcb_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MASK_W  = DATA_W / 8;
    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned BL_W    = 6;
    localparam int unsigned INSTR_W = 3;

    localparam logic [INSTR_W-1:0] CMD_WRITE    = 3'b000;
    localparam logic [INSTR_W-1:0] CMD_READ     = 3'b001;
    localparam logic [INSTR_W-1:0] CMD_WRITE_PC = 3'b010;
    localparam logic [INSTR_W-1:0] CMD_READ_PC  = 3'b011;
    localparam logic [INSTR_W-1:0] CMD_REFRESH  = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        WR_FILL,
        WR_CMD,
        RD_CMD,
        RD_DRAIN,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/artemis_mcb_port_master_if.sv
// Bundle of request, user data and MCB port signals for the port master.
//   master : view of the port master itself (drives req_ready, status, p_* strobes)
//   slave  : view of the surrounding logic / MCB (drives requests, data, FIFO flags)
interface artemis_mcb_port_master_if;
    import artemis_mcb_pkg::*;

    // request side
    logic                 calibration_done;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [BL_W-1:0]      req_bl;
    // user data side
    logic                 wdata_valid;
    logic                 wdata_ready;
    logic [DATA_W-1:0]    wdata;
    logic [MASK_W-1:0]    wmask;
    logic                 rdata_valid;
    logic                 rdata_ready;
    logic [DATA_W-1:0]    rdata;
    logic                 busy;
    logic                 done;
    logic                 err;
    // MCB command port
    logic                 p_cmd_en;
    logic [INSTR_W-1:0]   p_cmd_instr;
    logic [BL_W-1:0]      p_cmd_bl;
    logic [ADDR_W-1:0]    p_cmd_byte_addr;
    logic                 p_cmd_full;
    // MCB write port
    logic                 p_wr_en;
    logic [MASK_W-1:0]    p_wr_mask;
    logic [DATA_W-1:0]    p_wr_data;
    logic                 p_wr_full;
    logic                 p_wr_underrun;
    logic                 p_wr_error;
    // MCB read port
    logic                 p_rd_en;
    logic [DATA_W-1:0]    p_rd_data;
    logic                 p_rd_empty;
    logic                 p_rd_overflow;
    logic                 p_rd_error;

    modport master (
        input  calibration_done, req_valid, req_write, req_addr, req_bl,
               wdata_valid, wdata, wmask, rdata_ready,
               p_cmd_full, p_wr_full, p_wr_underrun, p_wr_error,
               p_rd_data, p_rd_empty, p_rd_overflow, p_rd_error,
        output req_ready, wdata_ready, rdata_valid, rdata, busy, done, err,
               p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
               p_wr_en, p_wr_mask, p_wr_data, p_rd_en
    );

    modport slave (
        output calibration_done, req_valid, req_write, req_addr, req_bl,
               wdata_valid, wdata, wmask, rdata_ready,
               p_cmd_full, p_wr_full, p_wr_underrun, p_wr_error,
               p_rd_data, p_rd_empty, p_rd_overflow, p_rd_error,
        input  req_ready, wdata_ready, rdata_valid, rdata, busy, done, err,
               p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
               p_wr_en, p_wr_mask, p_wr_data, p_rd_en
    );

endinterface

// File: rtl/artemis_mcb_watchdog.sv
// Progress watchdog for the MCB port master.
//   clk, rst : clock, asynchronous active-high reset
//   enable   : watched state active; counter held at zero otherwise
//   kick     : a transfer happened this cycle; clears the counter
//   count    : idle cycle to be counted
//   expired  : this idle cycle is the TIMEOUT-th in a row
module artemis_mcb_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Flags the cycle that brings the idle count to TIMEOUT, so the FSM
    // leaves on the same edge the count is reached.
    assign expired = enable && count && !kick && (cnt >= LIMIT_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || kick) begin
            cnt <= '0;
        end else if (count && (cnt < LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/artemis_mcb_port_master.sv
// Single-request master for one Xilinx MCB user port.
// Accepts a read or write burst request, moves bl+1 words through the MCB
// write/read FIFO and issues the command, then pulses done (err on failure).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : artemis_mcb_port_master_if.master (request, user data, MCB port)
// Parameter TIMEOUT: idle cycles without MCB progress before ERROR.
// Macro ARTEMIS_MCB_AUTO_PRECHARGE_EN: issue auto-precharge write/read commands.
module artemis_mcb_port_master
    import artemis_mcb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    artemis_mcb_port_master_if.master   bus
);

`ifdef ARTEMIS_MCB_AUTO_PRECHARGE_EN
    localparam logic [INSTR_W-1:0] INSTR_WR = CMD_WRITE_PC;
    localparam logic [INSTR_W-1:0] INSTR_RD = CMD_READ_PC;
`else
    localparam logic [INSTR_W-1:0] INSTR_WR = CMD_WRITE;
    localparam logic [INSTR_W-1:0] INSTR_RD = CMD_READ;
`endif

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic [BL_W-1:0]    bl_q;
    logic [INSTR_W-1:0] instr_q;
    logic [6:0]         word_cnt;
    logic               err_q;

    logic wr_phase, cmd_phase, rd_phase, watch;
    logic xfer, fault, expired, last_word;

    assign wr_phase  = (state == WR_FILL);
    assign cmd_phase = (state == WR_CMD) || (state == RD_CMD);
    assign rd_phase  = (state == RD_DRAIN);
    assign watch     = wr_phase || cmd_phase || rd_phase;

    // Accepts are also blocked while reset is held so nothing is taken on release.
    assign bus.req_ready   = (state == IDLE) && bus.calibration_done && !rst;
    assign bus.wdata_ready = wr_phase && !bus.p_wr_full;
    assign bus.p_wr_en     = bus.wdata_ready && bus.wdata_valid;
    assign bus.p_wr_data   = bus.wdata;
    assign bus.p_wr_mask   = bus.wmask;

    assign bus.p_cmd_en        = cmd_phase && !bus.p_cmd_full;
    assign bus.p_cmd_instr     = instr_q;
    assign bus.p_cmd_bl        = bl_q;
    assign bus.p_cmd_byte_addr = addr_q;

    assign bus.rdata_valid = rd_phase && !bus.p_rd_empty;
    assign bus.rdata       = bus.p_rd_data;
    assign bus.p_rd_en     = bus.rdata_valid && bus.rdata_ready;

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE) || (state == ERROR);
    assign bus.err  = err_q;

    assign xfer      = bus.p_wr_en || bus.p_cmd_en || bus.p_rd_en;
    assign fault     = bus.p_wr_underrun || bus.p_wr_error || bus.p_rd_overflow || bus.p_rd_error;
    // word_cnt holds words already moved; this transfer is word bl+1.
    assign last_word = (word_cnt == {1'b0, bl_q});

    artemis_mcb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (watch),
        .kick    (xfer),
        .count   (watch && !xfer),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            bl_q     <= '0;
            instr_q  <= '0;
            word_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        addr_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        bl_q     <= bus.req_bl;
                        instr_q  <= bus.req_write ? INSTR_WR : INSTR_RD;
                        word_cnt <= '0;
                        err_q    <= 1'b0;
                        state    <= bus.req_write ? WR_FILL : RD_CMD;
                    end
                end
                ERROR: state <= IDLE;
                default: begin
                    // FIFO faults and watchdog expiry override normal progress.
                    if (fault || expired) begin
                        err_q <= 1'b1;
                        state <= ERROR;
                    end else begin
                        case (state)
                            WR_FILL: if (bus.p_wr_en) begin
                                word_cnt <= word_cnt + 1'b1;
                                if (last_word) state <= WR_CMD;
                            end
                            WR_CMD:  if (bus.p_cmd_en) state <= DONE;
                            RD_CMD:  if (bus.p_cmd_en) state <= RD_DRAIN;
                            RD_DRAIN: if (bus.p_rd_en) begin
                                word_cnt <= word_cnt + 1'b1;
                                if (last_word) state <= DONE;
                            end
                            DONE:    state <= IDLE;
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_artemis_mcb_port_master.sv
// Directed bench for artemis_mcb_port_master with a scoreboard of expected
// MCB write words, commands, read words and done/err outcomes.
module tb_artemis_mcb_port_master;
    import artemis_mcb_pkg::*;

    localparam int unsigned TO = 16;
`ifdef ARTEMIS_MCB_AUTO_PRECHARGE_EN
    localparam logic [2:0] EXP_WR = 3'b010;
    localparam logic [2:0] EXP_RD = 3'b011;
`else
    localparam logic [2:0] EXP_WR = 3'b000;
    localparam logic [2:0] EXP_RD = 3'b001;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    artemis_mcb_port_master_if bus ();
    artemis_mcb_port_master #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_wr = 0, n_cmd = 0, n_rd = 0, n_done = 0;
    int cmd_cyc = 0, done_cyc = 0;

    logic [35:0] exp_wr[$];     // {mask, data}
    logic [38:0] exp_cmd[$];    // {instr, bl, addr}
    logic [31:0] exp_rd[$];
    logic        exp_done[$];   // err value at done
    logic [31:0] rd_src[$];     // MCB read FIFO contents
    logic        rd_stall = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wword(input int i);
        return 32'hD00D_0000 + 32'(i) * 32'h0001_0003;
    endfunction
    function automatic logic [3:0] wmk(input int i);
        return 4'hF ^ 4'(i);
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard side: every strobe pops and compares its expectation.
    always @(negedge clk) begin
        if (bus.p_wr_en) begin
            n_wr++;
            chk("wr_while_full", 64'(bus.p_wr_full), 64'd0);
            chk("wr_pending", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) chk("wr_word", 64'({bus.p_wr_mask, bus.p_wr_data}), 64'(exp_wr.pop_front()));
        end
        if (bus.p_cmd_en) begin
            n_cmd++;
            cmd_cyc = cyc;
            chk("cmd_pending", 64'(exp_cmd.size() != 0), 64'd1);
            if (exp_cmd.size() != 0)
                chk("cmd_fields", 64'({bus.p_cmd_instr, bus.p_cmd_bl, bus.p_cmd_byte_addr}), 64'(exp_cmd.pop_front()));
        end
        if (bus.p_rd_en) begin
            n_rd++;
            chk("rd_pending", 64'(exp_rd.size() != 0), 64'd1);
            if (exp_rd.size() != 0) chk("rd_word", 64'(bus.rdata), 64'(exp_rd.pop_front()));
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
            chk("done_pending", 64'(exp_done.size() != 0), 64'd1);
            if (exp_done.size() != 0) chk("done_err", 64'(bus.err), 64'(exp_done.pop_front()));
        end
    end

    // MCB read FIFO model: pops on a sampled p_rd_en, presents head word.
    initial begin : rd_model
        logic take;
        bus.p_rd_empty = 1'b1;
        bus.p_rd_data  = '0;
        forever begin
            @(negedge clk);
            take = bus.p_rd_en;
            @(posedge clk);
            #1;
            if (take && rd_src.size() != 0) void'(rd_src.pop_front());
            bus.p_rd_empty = rd_stall || (rd_src.size() == 0);
            bus.p_rd_data  = (rd_src.size() != 0) ? rd_src[0] : 32'h0;
        end
    end

    initial begin : global_limit
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic accept(input logic wr, input logic [29:0] addr, input logic [5:0] bl);
        bit ok = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_bl    = bl;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk("req_accepted", 64'(ok), 64'd1);
    endtask

    task automatic feed_wr(input int n, input int stall_lo, input int stall_hi);
        int idx = 0;
        for (int i = 0; i < n; i++) exp_wr.push_back({wmk(i), wword(i)});
        for (int c = 0; c < 400 && idx < n; c++) begin
            bus.wdata       = wword(idx);
            bus.wmask       = wmk(idx);
            bus.wdata_valid = 1'b1;
            bus.p_wr_full   = (c >= stall_lo) && (c <= stall_hi);
            @(negedge clk);
            if (bus.wdata_ready) idx++;
            @(posedge clk);
            #1;
        end
        bus.wdata_valid = 1'b0;
        bus.p_wr_full   = 1'b0;
        chk("wr_words_fed", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input bit toggle);
        bit seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (toggle) bus.rdata_ready = ~bus.rdata_ready;
            @(negedge clk);
            seen = bus.done;
            @(posedge clk);
            #1;
        end
        bus.rdata_ready = 1'b1;
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin : stim
        int b_wr, b_cmd, b_rd, b_done;
        bit got;
        rst = 1'b1;
        bus.calibration_done = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_bl = '0;
        bus.wdata_valid = 1'b1; bus.wdata = '0; bus.wmask = '0; bus.rdata_ready = 1'b1;
        bus.p_cmd_full = 1'b0; bus.p_wr_full = 1'b0; bus.p_wr_underrun = 1'b0; bus.p_wr_error = 1'b0;
        bus.p_rd_overflow = 1'b0; bus.p_rd_error = 1'b0;

        // reset state
        #2;
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_err", 64'(bus.err), 0);
        chk("rst_wdata_ready", 64'(bus.wdata_ready), 0);
        chk("rst_wr_en", 64'(bus.p_wr_en), 0);
        chk("rst_cmd_en", 64'(bus.p_cmd_en), 0);
        chk("rst_rd_en", 64'(bus.p_rd_en), 0);
        chk("rst_rdata_valid", 64'(bus.rdata_valid), 0);
        chk("rst_cmd_bl_addr", 64'({bus.p_cmd_bl, bus.p_cmd_byte_addr}), 0);
        bus.calibration_done = 1'b1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 0);
        bus.wdata_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 64'(bus.req_ready), 1);
        @(posedge clk); #1;

        // four-word write at 0x100
        b_wr = n_wr; b_cmd = n_cmd;
        exp_cmd.push_back({EXP_WR, 6'd3, 30'h100});
        exp_done.push_back(1'b0);
        accept(1'b1, 30'h100, 6'd3);
        chk("busy_in_fill", 64'(bus.busy), 1);
        feed_wr(4, -1, -1);
        wait_done(1'b0);
        chk("w4_wr_pulses", 64'(n_wr - b_wr), 4);
        chk("w4_cmd_pulses", 64'(n_cmd - b_cmd), 1);
        chk("w4_done_latency", 64'(done_cyc - cmd_cyc), 1);
        chk("idle_busy", 64'(bus.busy), 0);

        // eight-word read, ready toggling, calibration dropped mid-transfer
        b_rd = n_rd;
        for (int i = 0; i < 8; i++) begin
            rd_src.push_back(32'(i));
            exp_rd.push_back(32'(i));
        end
        exp_cmd.push_back({EXP_RD, 6'd7, 30'h2000});
        exp_done.push_back(1'b0);
        accept(1'b0, 30'h2000, 6'd7);
        bus.calibration_done = 1'b0;
        wait_done(1'b1);
        chk("r8_rd_pulses", 64'(n_rd - b_rd), 8);
        chk("r8_no_accept_uncal", 64'(bus.req_ready), 0);
        bus.calibration_done = 1'b1;

        // 64-word write with write FIFO full for fill cycles 10..19
        b_wr = n_wr;
        exp_cmd.push_back({EXP_WR, 6'd63, 30'h0ABC_DE00});
        exp_done.push_back(1'b0);
        accept(1'b1, 30'h0ABC_DE00, 6'd63);
        feed_wr(64, 10, 19);
        wait_done(1'b0);
        chk("w64_wr_pulses", 64'(n_wr - b_wr), 64);

        // read with the read FIFO stuck empty: 16 idle drain cycles then ERROR
        rd_stall = 1'b1;
        b_rd = n_rd;
        exp_cmd.push_back({EXP_RD, 6'd5, 30'h40});
        exp_done.push_back(1'b1);
        accept(1'b0, 30'h40, 6'd5);
        wait_done(1'b0);
        chk("to_latency", 64'(done_cyc - cmd_cyc), 17);
        b_done = n_done;
        repeat (5) @(posedge clk);
        #1;
        chk("to_no_rd_en", 64'(n_rd - b_rd), 0);
        chk("to_single_done", 64'(n_done - b_done), 0);
        chk("to_err_sticky", 64'(bus.err), 1);

        // read overflow during drain
        for (int i = 0; i < 4; i++) rd_src.push_back(32'hEE00 + 32'(i));
        exp_cmd.push_back({EXP_RD, 6'd3, 30'h80});
        exp_done.push_back(1'b1);
        accept(1'b0, 30'h80, 6'd3);
        b_cmd = n_cmd; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (n_cmd != b_cmd) || (exp_cmd.size() == 0);
            @(posedge clk); #1;
        end
        chk("ovf_cmd_seen", 64'(got), 1);
        bus.p_rd_overflow = 1'b1;
        @(posedge clk); #1;
        bus.p_rd_overflow = 1'b0;
        wait_done(1'b0);
        chk("ovf_err_idle", 64'(bus.err), 1);
        rd_src.delete();
        rd_stall = 1'b0;

        // next accept clears err; low address bits are forced to zero
        exp_cmd.push_back({EXP_WR, 6'd0, 30'h200});
        exp_done.push_back(1'b0);
        accept(1'b1, 30'h203, 6'd0);
        chk("err_cleared", 64'(bus.err), 0);
        feed_wr(1, -1, -1);
        wait_done(1'b0);

        // reset in the middle of a write fill
        accept(1'b1, 30'h300, 6'd7);
        feed_wr(2, -1, -1);
        bus.wdata_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 0);
        chk("mid_rst_wr_en", 64'(bus.p_wr_en), 0);
        chk("mid_rst_wdata_ready", 64'(bus.wdata_ready), 0);
        chk("mid_rst_done_err", 64'({bus.done, bus.err}), 0);
        chk("mid_rst_cmd", 64'({bus.p_cmd_en, bus.p_cmd_bl, bus.p_cmd_byte_addr}), 0);
        bus.wdata_valid = 1'b0;
        b_wr = n_wr; b_cmd = n_cmd;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_strobes", 64'((n_wr - b_wr) + (n_cmd - b_cmd)), 0);

        // same four-word write after reset
        b_wr = n_wr;
        exp_cmd.push_back({EXP_WR, 6'd3, 30'h100});
        exp_done.push_back(1'b0);
        accept(1'b1, 30'h100, 6'd3);
        feed_wr(4, -1, -1);
        wait_done(1'b0);
        chk("rerun_wr_pulses", 64'(n_wr - b_wr), 4);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(exp_wr.size() + exp_cmd.size() + exp_rd.size() + exp_done.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
